division: RTL and testbench

//   Multi-cycle unsigned integer divider for the CPU's DIVU path.

---
 rtl/div_pkg.sv | 12 +
 rtl/division.sv | 123 ++++++++++++
 tb/tb_division.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state type for the DIVU divider
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

endpackage

// File: rtl/division.sv
// rtl/division.sv - multi-cycle radix-2 restoring unsigned divider
module division
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t        r_state;
    div_state_t        w_next_state;
    logic [CW-1:0]     r_count;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_quo;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_r;
    logic              r_done;
    logic [2*WIDTH-1:0] w_step;
    logic              w_last;

    // One restoring step: shift {rem, quo} left, keep the difference when
    // the (WIDTH+1)-bit trial subtraction does not borrow. Returns {rem, quo}.
    // A zero divisor never borrows, which naturally yields q=all ones, r=a.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0]   sh;
        logic [WIDTH-1:0] diff;
        sh   = {rem, quo[WIDTH-1]};
        diff = WIDTH'(sh - {1'b0, dvs});
        if (sh >= {1'b0, dvs}) begin
            return {diff, quo[WIDTH-2:0], 1'b1};
        end
        return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    endfunction

    assign w_step = div_step(r_rem, r_quo, r_b);
    assign w_last = (r_count == LAST_ITER);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status decode; start during RUN is deliberately ignored.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start) begin
                    w_next_state = DIV_RUN;
                end
            end
            DIV_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DIV_IDLE;
                end
            end
            default: w_next_state = DIV_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_b     <= b;
                        r_rem   <= '0;
                        r_quo   <= a;
                        r_count <= '0;
                    end
                end
                DIV_RUN: begin
                    r_rem   <= w_step[2*WIDTH-1:WIDTH];
                    r_quo   <= w_step[WIDTH-1:0];
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_q    <= w_step[WIDTH-1:0];
                        r_r    <= w_step[2*WIDTH-1:WIDTH];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign done = r_done;

endmodule

// File: tb/tb_division.sv
// tb/tb_division.sv - randomized self-checking bench for the DIVU divider
module tb_division;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] q_out;
    logic [31:0] r_out;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    division dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .q     (q_out),
        .r     (r_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned division; zero divisor gives all-ones / dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return {32'hFFFF_FFFF, x};
        return {x / y, x % y};
    endfunction

    // Called at a negedge: launches an operation and watches it to completion.
    // Returns latency in cycles after the start edge (0 = never completed),
    // whether busy stayed high and q/r stayed frozen until completion.
    task automatic run_div(input logic [31:0] x, input logic [31:0] y,
                           output int lat, output logic [31:0] oq, output logic [31:0] orr,
                           output logic busy_ok, output logic hold_ok);
        logic [31:0] q0, r0;
        logic got;
        q0 = q_out; r0 = r_out;
        a_in = x; b_in = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = $urandom; b_in = $urandom;
        lat = 0; got = 1'b0; oq = 'x; orr = 'x;
        busy_ok = busy; hold_ok = 1'b1;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; lat = k; oq = q_out; orr = r_out;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (q_out !== q0 || r_out !== r0) hold_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({q_out, r_out, busy, done} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_state: q=%h r=%h busy=%b done=%b, want all zero", q_out, r_out, busy, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_one(input string name, input logic [31:0] x, input logic [31:0] y);
        int lat; logic [31:0] oq, orr; logic bok, hok; logic [63:0] e;
        e = ref_div(x, y);
        run_div(x, y, lat, oq, orr, bok, hok);
        n_cmp++;
        if (lat != 32) begin
            n_err++; $display("FAIL %s_latency: got %0d want 32", name, lat);
        end
        n_cmp++;
        if ({oq, orr} !== e) begin
            n_err++; $display("FAIL %s_result: a=%h b=%h got q=%h r=%h want q=%h r=%h", name, x, y, oq, orr, e[63:32], e[31:0]);
        end
        n_cmp++;
        if (!bok || !hok) begin
            n_err++; $display("FAIL %s_busy_hold: busy_ok=%b hold_ok=%b want 1 1", name, bok, hok);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s_done_pulse: done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_directed;
        check_one("a100_b7", 32'd100, 32'd7);
        check_one("max_b1", 32'hFFFF_FFFF, 32'd1);
        check_one("max_b16", 32'hFFFF_FFFF, 32'h10);
        check_one("a0", 32'd0, 32'd12345);
    endtask

    task automatic test_div_zero;
        check_one("div_zero", 32'd5, 32'd0);
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] oq, orr; logic bok, hok;
        run_div(32'd3, 32'd10, lat, oq, orr, bok, hok);
        n_cmp++;
        if (lat != 32 || oq !== 32'd0 || orr !== 32'd3) begin
            n_err++; $display("FAIL b2b_first: lat=%0d q=%0d r=%0d want 32 0 3", lat, oq, orr);
        end
        run_div(32'd81, 32'd9, lat, oq, orr, bok, hok);
        n_cmp++;
        if (lat != 32 || oq !== 32'd9 || orr !== 32'd0 || !bok) begin
            n_err++; $display("FAIL b2b_second: lat=%0d q=%0d r=%0d busy_ok=%b want 32 9 0 1", lat, oq, orr, bok);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int lat; logic got;
        a_in = 32'd1000; b_in = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (k == 10) begin
                start = 1'b1; a_in = 32'd50; b_in = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1; lat = k;
                n_cmp++;
                if (q_out !== 32'd333 || r_out !== 32'd1) begin
                    n_err++; $display("FAIL ignore_start_result: q=%0d r=%0d want 333 1", q_out, r_out);
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (lat != 32) begin
            n_err++; $display("FAIL ignore_start_latency: got %0d want 32", lat);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL ignore_start_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] oq, orr; logic bok, hok; logic saw_done;
        a_in = 32'd1000; b_in = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (q_out !== 32'd0 || r_out !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL abort_state: q=%h r=%h busy=%b done=%b want 0 0 0 0", q_out, r_out, busy, done);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_err++; $display("FAIL abort_no_done: activity after abort=1 want 0");
        end
        run_div(32'd9, 32'd2, lat, oq, orr, bok, hok);
        n_cmp++;
        if (lat != 32 || oq !== 32'd4 || orr !== 32'd1) begin
            n_err++; $display("FAIL abort_restart: lat=%0d q=%0d r=%0d want 32 4 1", lat, oq, orr);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            case (i % 4)
                0: y = $urandom;
                1: y = $urandom_range(1, 255);
                2: y = (i % 8 == 2) ? 32'd0 : x + 32'd1 + $urandom_range(0, 100);
                default: y = $urandom >> $urandom_range(0, 31);
            endcase
            check_one("random", x, y);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
